// File: rtl/spi_encoder_link.sv
// SPI mode-0 slave plus x4 quadrature decoder for the host link, single clk domain.
// Build option: define ENC_INDEX_EN to let a synced EncZ rising edge clear the encoder count.
module spi_encoder_link #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   SPI_CLK,
  input  logic                   CS,
  input  logic                   SPI_incoming,
  output logic                   SPI_outgoing,
  input  logic                   EncA,
  input  logic                   EncB,
  input  logic                   EncZ,
  output logic [DATA_WIDTH-1:0]  rx_word,
  output logic                   rx_valid,
  output logic [COUNT_WIDTH-1:0] enc_count,
  output logic                   enc_dir
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 2);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] OVER_CNT = CNT_W'(DATA_WIDTH + 1);
  // synchroniser bit order {sclk, cs, mosi, a, b}; CS idles high
  localparam logic [4:0] SYNC_RST = 5'b01000;
  localparam logic [DATA_WIDTH-1:0] PATTERN =
    {{(DATA_WIDTH - DATA_WIDTH/2){1'b1}}, {(DATA_WIDTH/2){1'b0}}};

  logic [SYNC_STAGES-1:0][4:0] sync_r;
  logic                        sclk_prev_r;
  logic                        cs_prev_r;
  logic [DATA_WIDTH-1:0]       rx_shift_r;
  logic [CNT_W-1:0]            bit_cnt_r;
  logic [DATA_WIDTH-1:0]       rx_word_r;
  logic                        frame_done_r;
  logic                        frame_done_prev_r;
  logic                        rx_valid_r;
  logic [DATA_WIDTH-1:0]       tx_shift_r;
  logic                        miso_r;
  logic [7:0]                  addr_reg_r;
  logic [1:0]                  ab_prev_r;
  logic [COUNT_WIDTH-1:0]      enc_count_r;
  logic                        enc_dir_r;

  logic                        sclk_s;
  logic                        cs_s;
  logic                        mosi_s;
  logic [1:0]                  ab_cur_s;
  logic                        sclk_rise_s;
  logic                        sclk_fall_s;
  logic                        cs_fall_s;
  logic                        cs_rise_s;
  logic [5:0]                  cmd_s;
  logic                        clear_cmd_s;
  logic                        index_s;
  logic                        clear_s;
  logic [1:0]                  step_s;
  logic [DATA_WIDTH-1:0]       reply_s;

  // Gray transition classifier on {B, A}: 2'b01 forward, 2'b10 reverse, 2'b00 none/illegal
  function automatic logic [1:0] quad_step(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] res;
    case ({prev, cur})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: res = 2'b01;
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: res = 2'b10;
      default:                                res = 2'b00;
    endcase
    return res;
  endfunction

  // input synchronisers for all asynchronous pins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_r <= {SYNC_STAGES{SYNC_RST}};
    end else begin
      sync_r[0] <= {SPI_CLK, CS, SPI_incoming, EncA, EncB};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  assign sclk_s   = sync_r[SYNC_STAGES-1][4];
  assign cs_s     = sync_r[SYNC_STAGES-1][3];
  assign mosi_s   = sync_r[SYNC_STAGES-1][2];
  assign ab_cur_s = {sync_r[SYNC_STAGES-1][0], sync_r[SYNC_STAGES-1][1]};

  // edge history for SPI clock and chip select
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_prev_r <= 1'b0;
      cs_prev_r   <= 1'b1;
    end else begin
      sclk_prev_r <= sclk_s;
      cs_prev_r   <= cs_s;
    end
  end

  // SPI clock edges only count while selected
  assign sclk_rise_s = sclk_s & ~sclk_prev_r & ~cs_s;
  assign sclk_fall_s = ~sclk_s & sclk_prev_r & ~cs_s;
  assign cs_fall_s   = ~cs_s & cs_prev_r;
  assign cs_rise_s   = cs_s & ~cs_prev_r;

  // receive shifter; an overrun parks the counter past full so the frame is dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_shift_r   <= {DATA_WIDTH{1'b0}};
      bit_cnt_r    <= {CNT_W{1'b0}};
      rx_word_r    <= {DATA_WIDTH{1'b0}};
      frame_done_r <= 1'b0;
    end else if (cs_fall_s) begin
      bit_cnt_r    <= {CNT_W{1'b0}};
      frame_done_r <= 1'b0;
    end else if (cs_rise_s) begin
      if (bit_cnt_r == FULL_CNT) begin
        rx_word_r    <= rx_shift_r;
        frame_done_r <= 1'b1;
      end
    end else if (sclk_rise_s) begin
      if (bit_cnt_r < FULL_CNT) begin
        rx_shift_r <= {rx_shift_r[DATA_WIDTH-2:0], mosi_s};
        bit_cnt_r  <= bit_cnt_r + CNT_W'(1);
      end else begin
        bit_cnt_r  <= OVER_CNT;
      end
    end
  end

  // one-clock valid pulse on the rising edge of frame_done
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_done_prev_r <= 1'b0;
      rx_valid_r        <= 1'b0;
    end else begin
      frame_done_prev_r <= frame_done_r;
      rx_valid_r        <= frame_done_r & ~frame_done_prev_r;
    end
  end

  // reply source selected by the last address command
  always_comb begin
    reply_s = {DATA_WIDTH{1'b0}};
    case (addr_reg_r)
      8'd0:    reply_s = rx_word_r;
      8'd1:    reply_s = DATA_WIDTH'({enc_dir_r, enc_count_r});
      8'd2:    reply_s = PATTERN;
      default: reply_s = {DATA_WIDTH{1'b0}};
    endcase
  end

  // transmit shifter; MISO presents the MSB at select and advances on SCLK fall
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_shift_r <= {DATA_WIDTH{1'b0}};
      miso_r     <= 1'b0;
    end else if (cs_fall_s) begin
      tx_shift_r <= reply_s;
      miso_r     <= reply_s[DATA_WIDTH-1];
    end else if (cs_s) begin
      miso_r     <= 1'b0;
    end else if (sclk_fall_s) begin
      tx_shift_r <= {tx_shift_r[DATA_WIDTH-2:0], 1'b0};
      miso_r     <= tx_shift_r[DATA_WIDTH-2];
    end
  end

  assign cmd_s       = rx_word_r[DATA_WIDTH-1 -: 6];
  assign clear_cmd_s = rx_valid_r && (cmd_s == 6'd3);

  // address register written by command 1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_reg_r <= 8'd0;
    end else if (rx_valid_r && (cmd_s == 6'd1)) begin
      addr_reg_r <= rx_word_r[7:0];
    end
  end

`ifdef ENC_INDEX_EN
  logic [SYNC_STAGES-1:0] z_sync_r;
  logic                   z_prev_r;

  // index synchroniser and edge history
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      z_sync_r <= {SYNC_STAGES{1'b0}};
      z_prev_r <= 1'b0;
    end else begin
      z_sync_r[0] <= EncZ;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        z_sync_r[i] <= z_sync_r[i-1];
      end
      z_prev_r <= z_sync_r[SYNC_STAGES-1];
    end
  end

  assign index_s = z_sync_r[SYNC_STAGES-1] & ~z_prev_r;
`else
  logic unused_enc_z_s;
  assign unused_enc_z_s = EncZ;
  assign index_s        = 1'b0;
`endif

  assign clear_s = clear_cmd_s | index_s;
  assign step_s  = quad_step(ab_prev_r, ab_cur_s);

  // position counter; a clear beats a simultaneous step
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ab_prev_r   <= 2'b00;
      enc_count_r <= {COUNT_WIDTH{1'b0}};
      enc_dir_r   <= 1'b0;
    end else begin
      ab_prev_r <= ab_cur_s;
      if (clear_s) begin
        enc_count_r <= {COUNT_WIDTH{1'b0}};
      end else if (step_s == 2'b01) begin
        enc_count_r <= enc_count_r + COUNT_WIDTH'(1);
        enc_dir_r   <= 1'b1;
      end else if (step_s == 2'b10) begin
        enc_count_r <= enc_count_r - COUNT_WIDTH'(1);
        enc_dir_r   <= 1'b0;
      end
    end
  end

  assign SPI_outgoing = miso_r;
  assign rx_word      = rx_word_r;
  assign rx_valid     = rx_valid_r;
  assign enc_count    = enc_count_r;
  assign enc_dir      = enc_dir_r;

endmodule

// File: tb/tb_spi_encoder_link.sv
// Scoreboard bench for spi_encoder_link: frames, replies, encoder steps, short/long frames, reset.
module tb_spi_encoder_link;

  localparam int HALF = 8;

  logic        clk;
  logic        reset;
  logic        SPI_CLK;
  logic        CS;
  logic        SPI_incoming;
  logic        SPI_outgoing;
  logic        EncA;
  logic        EncB;
  logic        EncZ;
  logic [31:0] rx_word;
  logic        rx_valid;
  logic [15:0] enc_count;
  logic        enc_dir;

  int n_checks;
  int n_fail;

  logic [31:0] rxq[$];

  logic [31:0] m_rx;
  logic [7:0]  m_addr;
  logic [15:0] m_count;
  logic        m_dir;
  int          phase;

  spi_encoder_link dut (
    .clk          (clk),
    .reset        (reset),
    .SPI_CLK      (SPI_CLK),
    .CS           (CS),
    .SPI_incoming (SPI_incoming),
    .SPI_outgoing (SPI_outgoing),
    .EncA         (EncA),
    .EncB         (EncB),
    .EncZ         (EncZ),
    .rx_word      (rx_word),
    .rx_valid     (rx_valid),
    .enc_count    (enc_count),
    .enc_dir      (enc_dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] model_reply();
    case (m_addr)
      8'd0:    return m_rx;
      8'd1:    return {15'd0, m_dir, m_count};
      8'd2:    return 32'hFFFF_0000;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [1:0] gray_of(input int p);
    case (p)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // rx_word scoreboard: every valid pulse must match the oldest full frame sent
  always @(negedge clk) begin
    if (reset && rx_valid) begin
      if (rxq.size() == 0) check_val("rx_valid_spurious", {31'd0, rx_valid}, 32'd0);
      else check_val("rx_word", rx_word, rxq.pop_front());
    end
  end

  task automatic spi_frame(input logic [31:0] word, input int nbits);
    logic [31:0] cap;
    logic [31:0] exp_reply;
    exp_reply = model_reply();
    if (nbits < 32) exp_reply = exp_reply >> (32 - nbits);
    else if (nbits > 32) exp_reply = exp_reply << (nbits - 32);
    if (nbits == 32) rxq.push_back(word);
    cap = 32'd0;
    CS = 1'b0;
    wait_clks(HALF);
    for (int i = 0; i < nbits; i++) begin
      SPI_incoming = (i < 32) ? word[31-i] : 1'b0;
      wait_clks(HALF);
      cap = {cap[30:0], SPI_outgoing};
      SPI_CLK = 1'b1;
      wait_clks(HALF);
      SPI_CLK = 1'b0;
    end
    wait_clks(HALF);
    CS = 1'b1;
    SPI_incoming = 1'b0;
    for (int k = 0; k < 20 && rxq.size() != 0; k++) wait_clks(1);
    check_val("rx_valid_latency", 32'(rxq.size()), 32'd0);
    check_val("miso_reply", cap, exp_reply);
    if (nbits == 32) begin
      m_rx = word;
      if (word[31:26] == 6'd1) m_addr = word[7:0];
      if (word[31:26] == 6'd3) m_count = 16'd0;
    end
    wait_clks(10);
  endtask

  // kind: 1 forward, -1 reverse, 2 both inputs toggle at once
  task automatic enc_move(input int kind);
    logic [1:0] g;
    if (kind == 1) begin
      phase = (phase + 1) % 4; m_count = m_count + 16'd1; m_dir = 1'b1;
    end else if (kind == -1) begin
      phase = (phase + 3) % 4; m_count = m_count - 16'd1; m_dir = 1'b0;
    end else begin
      phase = (phase + 2) % 4;
    end
    g = gray_of(phase);
    EncB = g[1];
    EncA = g[0];
    wait_clks(6);
  endtask

  task automatic check_enc(input string tag);
    check_val({tag, "_count"}, {16'd0, enc_count}, {16'd0, m_count});
    check_val({tag, "_dir"}, {31'd0, enc_dir}, {31'd0, m_dir});
  endtask

  initial begin
    logic [31:0] partial;
    n_checks = 0; n_fail = 0;
    m_rx = 32'd0; m_addr = 8'd0; m_count = 16'd0; m_dir = 1'b0; phase = 0;
    reset = 1'b0; SPI_CLK = 1'b0; CS = 1'b1; SPI_incoming = 1'b0;
    EncA = 1'b0; EncB = 1'b0; EncZ = 1'b0;
    wait_clks(5);
    reset = 1'b1;
    wait_clks(5);

    check_val("rst_rx_word", rx_word, 32'd0);
    check_val("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check_val("rst_miso", {31'd0, SPI_outgoing}, 32'd0);
    check_enc("rst");

    spi_frame(32'h0400_0001, 32);
    for (int i = 0; i < 4; i++) enc_move(1);
    check_enc("fwd4");
    spi_frame(32'h1234_5678, 32);
    spi_frame(32'h0400_0002, 32);
    spi_frame(32'hA5A5_A5A5, 32);
    spi_frame(32'hDEAD_BEEF, 32);
    spi_frame(32'h0400_0000, 32);
    spi_frame(32'h1111_1111, 32);

    spi_frame(32'h7FFF_FFFF, 31);
    check_val("short_rx_hold", rx_word, m_rx);
    spi_frame(32'h3333_3333, 33);
    check_val("long_rx_hold", rx_word, m_rx);
    spi_frame(32'h2222_2222, 32);

    spi_frame(32'h0C00_0000, 32);
    check_enc("cmd3_clear");
    enc_move(-1);
    check_enc("rev_wrap");
    enc_move(1);
    check_enc("fwd_wrap");
    enc_move(2);
    check_enc("illegal");

    for (int i = 0; i < 16; i++) enc_move(1);
    check_enc("fwd16");
    EncZ = 1'b1;
    wait_clks(6);
    EncZ = 1'b0;
    wait_clks(6);
`ifdef ENC_INDEX_EN
    m_count = 16'd0;
`endif
    check_enc("index");

    EncA = 1'b0; EncB = 1'b0; phase = 0;
    wait_clks(6);
    partial = 32'hC3C3_C3C3;
    CS = 1'b0;
    wait_clks(HALF);
    for (int i = 0; i < 16; i++) begin
      SPI_incoming = partial[31-i];
      wait_clks(HALF);
      SPI_CLK = 1'b1;
      wait_clks(HALF);
      SPI_CLK = 1'b0;
    end
    reset = 1'b0;
    wait_clks(3);
    CS = 1'b1;
    SPI_incoming = 1'b0;
    wait_clks(3);
    reset = 1'b1;
    m_rx = 32'd0; m_addr = 8'd0; m_count = 16'd0; m_dir = 1'b0;
    wait_clks(30);
    check_val("mid_rst_rx_word", rx_word, 32'd0);
    check_val("mid_rst_miso", {31'd0, SPI_outgoing}, 32'd0);
    check_enc("mid_rst");
    spi_frame(32'h5A5A_0F0F, 32);
    check_val("final_queue", 32'(rxq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
